pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter: DIV_LATENCY, 32, EX-stage cycles for a DIV/DIVU/REM/REMU op (legal 2..64).
REQ-002 SHALL have port: CLK  input  1  single clock; all state changes on posedge.
REQ-003 SHALL have port: Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: ID_rs1  input  5  source reg 1 of instruction in ID.
REQ-005 SHALL have port: ID_rs2  input  5  source reg 2 of instruction in ID.
REQ-006 SHALL have port: ID_uses_rs1  input  1  ID instruction reads rs1.
REQ-007 SHALL have port: ID_uses_rs2  input  1  ID instruction reads rs2.
REQ-008 SHALL have port: EX_mem_read  input  1  EX instruction is a load.
REQ-009 SHALL have port: EX_rd  input  5  EX destination register.
REQ-010 SHALL have port: EX_div_start  input  1  divide/remainder op entered EX this cycle.
REQ-011 SHALL have port: EX_branch_taken  input  1  EX resolved taken branch/jump.
REQ-012 SHALL have outputs, 1 bit each: PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush, EX_MEM_bubble, div_busy, div_done.
REQ-013 SHALL have port: stall_cycles  output  32  stall-cycle performance count.

Function
REQ-014 SHALL implement FSM states RUN, DIV_BUSY, DIV_DONE; state register and 6-bit down-counter div_cnt.
REQ-015 SHALL define load_use = EX_mem_read & (EX_rd!=0) & ((ID_uses_rs1 & ID_rs1==EX_rd) | (ID_uses_rs2 & ID_rs2==EX_rd)), combinational.
REQ-016 SHALL, in RUN with EX_branch_taken=1: IF_ID_flush=1, ID_EX_flush=1, PC_write=1, IF_ID_write=1, ID_EX_write=1; load_use ignored (branch wins).
REQ-017 SHALL, in RUN with load_use=1 and no branch: PC_write=0, IF_ID_write=0, ID_EX_flush=1 for exactly that cycle (one bubble).
REQ-018 SHALL, in RUN with no hazard: PC_write=IF_ID_write=ID_EX_write=1, all flush/bubble outputs 0.
REQ-019 SHALL, in RUN with EX_div_start=1 (and no branch), load div_cnt=DIV_LATENCY-2 and enter DIV_BUSY next cycle; that cycle already freezes PC, IF/ID, ID/EX and sets EX_MEM_bubble=1.
REQ-020 SHALL, in DIV_BUSY: PC_write=IF_ID_write=ID_EX_write=0, EX_MEM_bubble=1, div_busy=1, decrement div_cnt; at div_cnt==0 go to DIV_DONE.
REQ-021 SHALL, in DIV_DONE (one cycle): div_done=1, EX_MEM_bubble=0, pipeline writes 1, return to RUN; EX_div_start ignored in this cycle.
REQ-022 SHALL guarantee total EX residency of a divide = DIV_LATENCY cycles (start cycle + DIV_LATENCY-2 busy + done).
REQ-023 SHALL ignore EX_branch_taken, load_use and EX_div_start while in DIV_BUSY.
REQ-024 SHALL never assert IF_ID_write and IF_ID_flush together except on taken branch (flush dominates).
REQ-025 SHALL never gate MEM/WB; older instructions drain during every stall.

Reset
REQ-026 SHALL, on posedge CLK with Reset=1: state=RUN, div_cnt=0, stall_cycles=0.
REQ-027 SHALL, while Reset=1: PC_write=IF_ID_write=ID_EX_write=0, IF_ID_flush=ID_EX_flush=1, EX_MEM_bubble=1, div_busy=div_done=0.
REQ-028 SHALL abort a divide on Reset mid-DIV_BUSY; first cycle after Reset deasserts is RUN.

Configuration
REQ-029 SHALL, with HAZARD_PERF_CNT_EN defined, increment stall_cycles (wrapping 0xFFFFFFFF->0) on each non-reset cycle with PC_write=0.
REQ-030 SHALL, without HAZARD_PERF_CNT_EN, tie stall_cycles to 0 and synthesize no counter.

Structure
REQ-031 SHALL place state encoding typedef (RUN/DIV_BUSY/DIV_DONE) and default DIV_LATENCY in shared package pipeline_pkg.
REQ-032 SHALL be a single module; no sub-modules.

Verification
REQ-033 SHALL cover: load x5 in EX, ID reads x5 via rs2 -> one cycle PC_write=0, ID_EX_flush=1; next cycle all writes 1.
REQ-034 SHALL cover: load x0 in EX, ID reads x0 -> no stall.
REQ-035 SHALL cover: DIV_LATENCY=32, EX_div_start pulse -> div_busy high 30 cycles, div_done 1 cycle, PC_write low 31 cycles.
REQ-036 SHALL cover: EX_branch_taken and load_use same cycle -> both flushes 1, PC_write=1.
REQ-037 SHALL cover: Reset at 10th DIV_BUSY cycle -> next post-reset cycle RUN, div_busy=0, stall_cycles=0.
REQ-038 SHALL cover, with HAZARD_PERF_CNT_EN: one load-use stall plus one divide (DIV_LATENCY=4) -> stall_cycles=4.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding
// and the default divider latency.
package pipeline_pkg;
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } hz_state_t;

   localparam int DIV_LATENCY_DEF = 32;
endpackage

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, multi-cycle divide freeze.
// Optional stall-cycle counter is built only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int DIV_LATENCY = DIV_LATENCY_DEF
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic [4:0]  ID_rs1,
   input  logic [4:0]  ID_rs2,
   input  logic        ID_uses_rs1,
   input  logic        ID_uses_rs2,
   input  logic        EX_mem_read,
   input  logic [4:0]  EX_rd,
   input  logic        EX_div_start,
   input  logic        EX_branch_taken,
   output logic        PC_write,
   output logic        IF_ID_write,
   output logic        IF_ID_flush,
   output logic        ID_EX_write,
   output logic        ID_EX_flush,
   output logic        EX_MEM_bubble,
   output logic        div_busy,
   output logic        div_done,
   output logic [31:0] stall_cycles
);

   localparam logic [5:0] DIV_LOAD = 6'(DIV_LATENCY - 2);

   hz_state_t  state;
   logic [5:0] div_cnt;
   logic       load_use;

   assign load_use = EX_mem_read && (EX_rd != 5'd0) &&
                     ((ID_uses_rs1 && (ID_rs1 == EX_rd)) ||
                      (ID_uses_rs2 && (ID_rs2 == EX_rd)));

   always_comb begin
      PC_write      = 1'b1;
      IF_ID_write   = 1'b1;
      IF_ID_flush   = 1'b0;
      ID_EX_write   = 1'b1;
      ID_EX_flush   = 1'b0;
      EX_MEM_bubble = 1'b0;
      div_busy      = 1'b0;
      div_done      = 1'b0;
      if (Reset) begin
         PC_write      = 1'b0;
         IF_ID_write   = 1'b0;
         ID_EX_write   = 1'b0;
         IF_ID_flush   = 1'b1;
         ID_EX_flush   = 1'b1;
         EX_MEM_bubble = 1'b1;
      end else begin
         case (state)
            RUN: begin
               if (EX_branch_taken) begin
                  IF_ID_flush = 1'b1;
                  ID_EX_flush = 1'b1;
               end else if (EX_div_start) begin
                  PC_write      = 1'b0;
                  IF_ID_write   = 1'b0;
                  ID_EX_write   = 1'b0;
                  EX_MEM_bubble = 1'b1;
               end else if (load_use) begin
                  PC_write    = 1'b0;
                  IF_ID_write = 1'b0;
                  ID_EX_flush = 1'b1;
               end
            end
            DIV_BUSY: begin
               PC_write      = 1'b0;
               IF_ID_write   = 1'b0;
               ID_EX_write   = 1'b0;
               EX_MEM_bubble = 1'b1;
               div_busy      = 1'b1;
            end
            DIV_DONE: div_done = 1'b1;
            default: ;
         endcase
      end
   end

   // div_cnt holds the busy cycles still to come; leaving on 1 lands the
   // counter on 0 as DIV_DONE is entered, giving exactly DIV_LATENCY-2 busy cycles.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state   <= RUN;
         div_cnt <= 6'd0;
      end else begin
         case (state)
            RUN: begin
               if (!EX_branch_taken && EX_div_start) begin
                  div_cnt <= DIV_LOAD;
                  state   <= (DIV_LATENCY <= 2) ? DIV_DONE : DIV_BUSY;
               end
            end
            DIV_BUSY: begin
               if (div_cnt != 6'd0) div_cnt <= div_cnt - 6'd1;
               if (div_cnt <= 6'd1) state <= DIV_DONE;
            end
            DIV_DONE: state <= RUN;
            default:  state <= RUN;
         endcase
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_q;

   always_ff @(posedge CLK) begin
      if (Reset)         stall_q <= 32'd0;
      else if (!PC_write) stall_q <= stall_q + 32'd1;
   end

   assign stall_cycles = stall_q;
`else
   assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized + directed bench for pipeline_hazard_ctrl; two instances
// (DIV_LATENCY 32 and 4) share stimulus and are checked against a cycle model.
module tb_pipeline_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rs1, rs2, ex_rd;
   logic        u1, u2, mr, ds, br;

   logic        pcw_a, ifw_a, iff_a, idw_a, idf_a, bub_a, busy_a, done_a;
   logic        pcw_b, ifw_b, iff_b, idw_b, idf_b, bub_b, busy_b, done_b;
   logic [31:0] sc_a, sc_b;

   int checks   = 0;
   int failures = 0;

   // model state: remaining EX cycles of an in-flight divide (0 = none)
   int dl_a = 0, dl_b = 0;
   int cnt_a = 0, cnt_b = 0;
   int n_busy, n_done, n_pcl;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.DIV_LATENCY(32)) dut_a (
      .CLK(clk), .Reset(rst), .ID_rs1(rs1), .ID_rs2(rs2), .ID_uses_rs1(u1), .ID_uses_rs2(u2),
      .EX_mem_read(mr), .EX_rd(ex_rd), .EX_div_start(ds), .EX_branch_taken(br),
      .PC_write(pcw_a), .IF_ID_write(ifw_a), .IF_ID_flush(iff_a), .ID_EX_write(idw_a),
      .ID_EX_flush(idf_a), .EX_MEM_bubble(bub_a), .div_busy(busy_a), .div_done(done_a),
      .stall_cycles(sc_a));

   pipeline_hazard_ctrl #(.DIV_LATENCY(4)) dut_b (
      .CLK(clk), .Reset(rst), .ID_rs1(rs1), .ID_rs2(rs2), .ID_uses_rs1(u1), .ID_uses_rs2(u2),
      .EX_mem_read(mr), .EX_rd(ex_rd), .EX_div_start(ds), .EX_branch_taken(br),
      .PC_write(pcw_b), .IF_ID_write(ifw_b), .IF_ID_flush(iff_b), .ID_EX_write(idw_b),
      .ID_EX_flush(idf_b), .EX_MEM_bubble(bub_b), .div_busy(busy_b), .div_done(done_b),
      .stall_cycles(sc_b));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // expected {PC_w, IFID_w, IFID_fl, IDEX_w, IDEX_fl, bubble, busy, done}
   function automatic logic [7:0] exp_out(int dl, bit r, bit lu, bit b, bit d);
      if (r)       return 8'b0010_1100;
      if (dl > 1)  return 8'b0000_0110;
      if (dl == 1) return 8'b1101_0001;
      if (b)       return 8'b1111_1000;
      if (d)       return 8'b0000_0100;
      if (lu)      return 8'b0001_1000;
      return 8'b1101_0000;
   endfunction

   function automatic int next_dl(int dl, int lat, bit r, bit b, bit d);
      if (r)      return 0;
      if (dl > 0) return dl - 1;
      if (d && !b) return lat - 1;
      return 0;
   endfunction

   function automatic logic [31:0] exp_cnt(int c);
`ifdef HAZARD_PERF_CNT_EN
      return 32'(c);
`else
      return 32'd0;
`endif
   endfunction

   task automatic step(input bit r, input logic [4:0] s1, input logic [4:0] s2, input bit e1,
                       input bit e2, input bit m, input logic [4:0] rd, input bit d, input bit b);
      logic [7:0] ea, eb;
      bit lu;
      rst = r; rs1 = s1; rs2 = s2; u1 = e1; u2 = e2; mr = m; ex_rd = rd; ds = d; br = b;
      #1;
      lu = m && (rd != 0) && ((e1 && s1 == rd) || (e2 && s2 == rd));
      ea = exp_out(dl_a, r, lu, b, d);
      eb = exp_out(dl_b, r, lu, b, d);
      chk("outs_L32", {pcw_a, ifw_a, iff_a, idw_a, idf_a, bub_a, busy_a, done_a}, 32'(ea));
      chk("outs_L4",  {pcw_b, ifw_b, iff_b, idw_b, idf_b, bub_b, busy_b, done_b}, 32'(eb));
      chk("stall_L32", sc_a, exp_cnt(cnt_a));
      chk("stall_L4",  sc_b, exp_cnt(cnt_b));
      n_busy += int'(busy_a); n_done += int'(done_a); n_pcl += int'(!pcw_a);
      cnt_a = r ? 0 : cnt_a + int'(!ea[7]);
      cnt_b = r ? 0 : cnt_b + int'(!eb[7]);
      dl_a = next_dl(dl_a, 32, r, b, d);
      dl_b = next_dl(dl_b, 4, r, b, d);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 5'd1, 5'd2, 1, 1, 0, 5'd0, 0, 0);
   endtask

   initial begin
      rst = 1; rs1 = 0; rs2 = 0; u1 = 0; u2 = 0; mr = 0; ex_rd = 0; ds = 0; br = 0;
      @(negedge clk);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(2);

      // load x5 in EX, ID reads x5 via rs2: one bubble, then free-running
      step(0, 5'd3, 5'd5, 1, 1, 1, 5'd5, 0, 0);
      idle(1);
      // load x0 in EX, ID reads x0: no stall
      step(0, 5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 0);
      // branch and load-use together: branch wins
      step(0, 5'd7, 5'd2, 1, 0, 1, 5'd7, 0, 1);

      // full divide on the 32-cycle instance
      n_busy = 0; n_done = 0; n_pcl = 0;
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      idle(35);
      chk("div_busy_len", 32'(n_busy), 32'd30);
      chk("div_done_len", 32'(n_done), 32'd1);
      chk("pc_low_len", 32'(n_pcl), 32'd31);

      // reset on 10th busy cycle aborts the divide
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      idle(9);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(1);
      chk("post_rst_busy", 32'(busy_a), 32'd0);
      chk("post_rst_stall", sc_a, 32'd0);

      // one load-use stall plus one 4-cycle divide on the small instance
      step(0, 5'd9, 5'd1, 1, 0, 1, 5'd9, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      idle(40);
      chk("stall_L4_total", sc_b, exp_cnt(4));

      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 199) == 0,
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0,
              5'($urandom_range(0, 3)),
              $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
